// File: rtl/sauria_cfg_sequencer.sv
// Command-driven AXI4-Lite config sequencer: WRITE/READ/POLL/DONE, one txn at a time.
// Optional SAURIA_CFG_SEQ_RESP_CHECK_EN flags non-OKAY bresp/rresp on o_resp_err.
module sauria_cfg_sequencer #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int POLL_TIMEOUT = 65535,
    parameter int POLL_GAP     = 4
) (
    input  logic              i_system_clk,
    input  logic              i_system_rstn,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_data,
    input  logic [DATA_W-1:0] i_cmd_mask,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic [ADDR_W-1:0] o_cfg_axi_awaddr,
    output logic              o_cfg_axi_awvalid,
    input  logic              i_cfg_axi_awready,
    output logic [DATA_W-1:0] o_cfg_axi_wdata,
    output logic              o_cfg_axi_wvalid,
    input  logic              i_cfg_axi_wready,
    input  logic [1:0]        i_cfg_axi_bresp,
    input  logic              i_cfg_axi_bvalid,
    output logic              o_cfg_axi_bready,
    output logic [ADDR_W-1:0] o_cfg_axi_araddr,
    output logic              o_cfg_axi_arvalid,
    input  logic              i_cfg_axi_arready,
    input  logic [DATA_W-1:0] i_cfg_axi_rdata,
    input  logic [1:0]        i_cfg_axi_rresp,
    input  logic              i_cfg_axi_rvalid,
    output logic              o_cfg_axi_rready,
    output logic              o_check_flag,
    output logic              o_timeout_err,
    output logic              o_resp_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD,
        ST_RD_DATA,
        ST_POLL_GAP,
        ST_DONE
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_POLL  = 2'd2;
    localparam logic [1:0] OP_DONE  = 2'd3;

    localparam logic [31:0] GAP_LAST = (POLL_GAP > 0) ? 32'(POLL_GAP - 1) : 32'd0;
    localparam logic [31:0] TO_LAST  = (POLL_TIMEOUT > 0) ? 32'(POLL_TIMEOUT - 1) : 32'd0;

    state_t            state;
    logic              is_poll;
    logic [DATA_W-1:0] poll_exp;
    logic [DATA_W-1:0] poll_mask;
    logic [31:0]       poll_cnt;
    logic [31:0]       gap_cnt;
    logic              accept;
    logic              aw_done;
    logic              w_done;
    logic              poll_hit;

    assign o_cmd_ready = (state == ST_IDLE) || (state == ST_DONE);
    assign accept      = i_cmd_valid && o_cmd_ready;
    assign aw_done     = !o_cfg_axi_awvalid || i_cfg_axi_awready;
    assign w_done      = !o_cfg_axi_wvalid || i_cfg_axi_wready;
    assign poll_hit    = ((i_cfg_axi_rdata ^ poll_exp) & poll_mask) == '0;

    // Flag drops combinationally in the cycle a non-DONE command is taken.
    assign o_check_flag = (state == ST_DONE) &&
                          !(i_cmd_valid && (i_cmd_op != OP_DONE));

    always_ff @(posedge i_system_clk or negedge i_system_rstn) begin
        if (!i_system_rstn) begin
            state             <= ST_IDLE;
            is_poll           <= 1'b0;
            poll_exp          <= '0;
            poll_mask         <= '0;
            poll_cnt          <= '0;
            gap_cnt           <= '0;
            o_rsp_valid       <= 1'b0;
            o_rsp_data        <= '0;
            o_cfg_axi_awaddr  <= '0;
            o_cfg_axi_awvalid <= 1'b0;
            o_cfg_axi_wdata   <= '0;
            o_cfg_axi_wvalid  <= 1'b0;
            o_cfg_axi_bready  <= 1'b0;
            o_cfg_axi_araddr  <= '0;
            o_cfg_axi_arvalid <= 1'b0;
            o_cfg_axi_rready  <= 1'b0;
            o_timeout_err     <= 1'b0;
        end else begin
            o_rsp_valid <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        poll_cnt <= '0;
                        unique case (i_cmd_op)
                            OP_WRITE: begin
                                o_cfg_axi_awaddr  <= i_cmd_addr;
                                o_cfg_axi_wdata   <= i_cmd_data;
                                o_cfg_axi_awvalid <= 1'b1;
                                o_cfg_axi_wvalid  <= 1'b1;
                                state             <= ST_WR;
                            end
                            OP_READ, OP_POLL: begin
                                o_cfg_axi_araddr  <= i_cmd_addr;
                                o_cfg_axi_arvalid <= 1'b1;
                                is_poll           <= (i_cmd_op == OP_POLL);
                                poll_exp          <= i_cmd_data;
                                poll_mask         <= i_cmd_mask;
                                state             <= ST_RD;
                            end
                            default: state <= ST_DONE;
                        endcase
                    end
                end
                ST_WR: begin
                    if (i_cfg_axi_awready) o_cfg_axi_awvalid <= 1'b0;
                    if (i_cfg_axi_wready)  o_cfg_axi_wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        o_cfg_axi_bready <= 1'b1;
                        state            <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (i_cfg_axi_bvalid) begin
                        o_cfg_axi_bready <= 1'b0;
                        state            <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    if (i_cfg_axi_arready) begin
                        o_cfg_axi_arvalid <= 1'b0;
                        o_cfg_axi_rready  <= 1'b1;
                        state             <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (i_cfg_axi_rvalid) begin
                        o_cfg_axi_rready <= 1'b0;
                        if (!is_poll) begin
                            o_rsp_valid <= 1'b1;
                            o_rsp_data  <= i_cfg_axi_rdata;
                            state       <= ST_IDLE;
                        end else if (poll_hit) begin
                            state <= ST_IDLE;
                        end else if (poll_cnt >= TO_LAST) begin
                            poll_cnt      <= poll_cnt + 32'd1;
                            o_timeout_err <= 1'b1;
                            state         <= ST_IDLE;
                        end else begin
                            poll_cnt <= poll_cnt + 32'd1;
                            gap_cnt  <= '0;
                            state    <= ST_POLL_GAP;
                        end
                    end
                end
                ST_POLL_GAP: begin
                    if (gap_cnt >= GAP_LAST) begin
                        o_cfg_axi_arvalid <= 1'b1;
                        state             <= ST_RD;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SAURIA_CFG_SEQ_RESP_CHECK_EN
    always_ff @(posedge i_system_clk or negedge i_system_rstn) begin
        if (!i_system_rstn) begin
            o_resp_err <= 1'b0;
        end else if ((i_cfg_axi_bvalid && o_cfg_axi_bready && (i_cfg_axi_bresp != 2'b00)) ||
                     (i_cfg_axi_rvalid && o_cfg_axi_rready && (i_cfg_axi_rresp != 2'b00))) begin
            o_resp_err <= 1'b1;
        end
    end
`else
    logic unused_resp;
    assign unused_resp = ^{i_cfg_axi_bresp, i_cfg_axi_rresp};
    assign o_resp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_sauria_cfg_sequencer.sv
// Directed bench for sauria_cfg_sequencer with a simple AXI4-Lite slave driver.
// Resp-error expectation follows SAURIA_CFG_SEQ_RESP_CHECK_EN.
module tb_sauria_cfg_sequencer;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int PT = 8;
    localparam int PG = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic [DW-1:0] cmd_mask = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready = 1'b0;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready = 1'b0;
    logic [1:0]    bresp = '0;
    logic          bvalid = 1'b0;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic [1:0]    rresp = '0;
    logic          rvalid = 1'b0;
    logic          rready;
    logic          check_flag;
    logic          timeout_err;
    logic          resp_err;

    always #5 clk = ~clk;

    sauria_cfg_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .POLL_TIMEOUT(PT), .POLL_GAP(PG)
    ) dut (
        .i_system_clk(clk),
        .i_system_rstn(rst_n),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op),
        .i_cmd_addr(cmd_addr),
        .i_cmd_data(cmd_data),
        .i_cmd_mask(cmd_mask),
        .o_rsp_valid(rsp_valid),
        .o_rsp_data(rsp_data),
        .o_cfg_axi_awaddr(awaddr),
        .o_cfg_axi_awvalid(awvalid),
        .i_cfg_axi_awready(awready),
        .o_cfg_axi_wdata(wdata),
        .o_cfg_axi_wvalid(wvalid),
        .i_cfg_axi_wready(wready),
        .i_cfg_axi_bresp(bresp),
        .i_cfg_axi_bvalid(bvalid),
        .o_cfg_axi_bready(bready),
        .o_cfg_axi_araddr(araddr),
        .o_cfg_axi_arvalid(arvalid),
        .i_cfg_axi_arready(arready),
        .i_cfg_axi_rdata(rdata),
        .i_cfg_axi_rresp(rresp),
        .i_cfg_axi_rvalid(rvalid),
        .o_cfg_axi_rready(rready),
        .o_check_flag(check_flag),
        .o_timeout_err(timeout_err),
        .o_resp_err(resp_err)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int aw_n = 0;
    int w_n = 0;
    int ar_n = 0;
    int rsp_n = 0;
    int ar_cyc [64];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (awvalid && awready) aw_n <= aw_n + 1;
            if (wvalid && wready) w_n <= w_n + 1;
            if (rsp_valid) rsp_n <= rsp_n + 1;
            if (arvalid && arready) begin
                if (ar_n < 64) ar_cyc[ar_n] <= cyc;
                ar_n <= ar_n + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] mask);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_mask  = mask;
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic rd_slave(input logic [31:0] d, input logic [1:0] resp,
                            input int lat);
        @(negedge clk);
        for (int i = 0; i < 64 && !arvalid; i++) @(negedge clk);
        check("ar_wait", 32'(arvalid), 32'd1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        repeat (lat) @(negedge clk);
        rvalid = 1'b1;
        rdata  = d;
        rresp  = resp;
        @(negedge clk);
        rvalid = 1'b0;
        rresp  = '0;
    endtask

    task automatic wr_slave(input logic [1:0] resp);
        @(negedge clk);
        for (int i = 0; i < 64 && !awvalid; i++) @(negedge clk);
        check("aw_wait", 32'(awvalid), 32'd1);
        awready = 1'b1;
        wready  = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        wready  = 1'b0;
        for (int i = 0; i < 64 && !bready; i++) @(negedge clk);
        check("b_wait", 32'(bready), 32'd1);
        bvalid = 1'b1;
        bresp  = resp;
        @(negedge clk);
        bvalid = 1'b0;
        bresp  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int r0;
        #12;
        check("rst_awvalid", 32'(awvalid), 32'd0);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_flag", 32'(check_flag), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // WRITE with awready one cycle before wready
        send(2'd0, 32'h10, 32'hCAFE, 32'h0);
        @(negedge clk);
        check("wr_awvalid", 32'(awvalid), 32'd1);
        check("wr_wvalid", 32'(wvalid), 32'd1);
        check("wr_awaddr", awaddr, 32'h10);
        check("wr_wdata", wdata, 32'hCAFE);
        check("wr_bready_early", 32'(bready), 32'd0);
        check("wr_busy", 32'(cmd_ready), 32'd0);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        check("wr_aw_drop", 32'(awvalid), 32'd0);
        check("wr_w_hold", 32'(wvalid), 32'd1);
        check("wr_bready_mid", 32'(bready), 32'd0);
        wready = 1'b1;
        @(negedge clk);
        wready = 1'b0;
        check("wr_w_drop", 32'(wvalid), 32'd0);
        check("wr_bready", 32'(bready), 32'd1);
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        check("wr_bready_off", 32'(bready), 32'd0);
        check("wr_idle", 32'(cmd_ready), 32'd1);
        check("wr_aw_count", aw_n, 1);
        check("wr_w_count", w_n, 1);

        // READ, data three cycles after rready
        send(2'd1, 32'h20, 32'h0, 32'h0);
        @(negedge clk);
        check("rd_araddr", araddr, 32'h20);
        rd_slave(32'h1234, 2'b00, 3);
        check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_rsp_data", rsp_data, 32'h1234);
        @(negedge clk);
        check("rd_rsp_pulse", 32'(rsp_valid), 32'd0);
        check("rd_rsp_count", rsp_n, 1);
        check("rd_idle", 32'(cmd_ready), 32'd1);

        // POLL that matches on the third read
        base = ar_n;
        r0   = rsp_n;
        send(2'd2, 32'h30, 32'h1, 32'h1);
        rd_slave(32'h0, 2'b00, 0);
        rd_slave(32'h0, 2'b00, 0);
        rd_slave(32'h1, 2'b00, 0);
        @(negedge clk);
        check("poll_ar_count", ar_n - base, 3);
        check("poll_gap1", 32'((ar_cyc[base+1] - ar_cyc[base]) >= PG + 1), 32'd1);
        check("poll_gap2", 32'((ar_cyc[base+2] - ar_cyc[base+1]) >= PG + 1), 32'd1);
        check("poll_no_rsp", rsp_n - r0, 0);
        check("poll_idle", 32'(cmd_ready), 32'd1);
        check("poll_no_timeout", 32'(timeout_err), 32'd0);

        // POLL that never matches
        base = ar_n;
        send(2'd2, 32'h40, 32'h5A, 32'hFF);
        for (int k = 0; k < PT; k++) begin
            rd_slave(32'h0, 2'b00, 0);
            if (k == PT - 2) check("to_not_yet", 32'(timeout_err), 32'd0);
        end
        check("to_err", 32'(timeout_err), 32'd1);
        check("to_idle", 32'(cmd_ready), 32'd1);
        repeat (10) @(negedge clk);
        check("to_no_more_ar", 32'(arvalid), 32'd0);
        check("to_ar_count", ar_n - base, PT);
        check("to_resp_err", 32'(resp_err), 32'd0);

        // DONE, DONE again, then WRITE
        check("flag_pre", 32'(check_flag), 32'd0);
        send(2'd3, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("flag_rise", 32'(check_flag), 32'd1);
        send(2'd3, 32'h0, 32'h0, 32'h0);
        check("flag_hold", 32'(check_flag), 32'd1);
        @(negedge clk);
        check("flag_hold2", 32'(check_flag), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_addr  = 32'h50;
        cmd_data  = 32'h77;
        #1;
        check("flag_fall_accept", 32'(check_flag), 32'd0);
        check("flag_done_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("flag_after", 32'(check_flag), 32'd0);
        wr_slave(2'b00);
        check("wr2_idle", 32'(cmd_ready), 32'd1);

        // Reset mid-write, then a READ with SLVERR
        send(2'd0, 32'h60, 32'h99, 32'h0);
        @(negedge clk);
        check("rst_mid_awvalid_pre", 32'(awvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_awvalid", 32'(awvalid), 32'd0);
        check("rst_mid_wvalid", 32'(wvalid), 32'd0);
        check("rst_mid_awaddr", awaddr, 32'h0);
        check("rst_mid_timeout", 32'(timeout_err), 32'd0);
        check("rst_mid_ready", 32'(cmd_ready), 32'd1);
        check("rst_mid_resp_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(2'd1, 32'h70, 32'h0, 32'h0);
        rd_slave(32'hBEEF, 2'b10, 1);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        check("post_rst_rsp_data", rsp_data, 32'hBEEF);
`ifdef SAURIA_CFG_SEQ_RESP_CHECK_EN
        check("resp_err_set", 32'(resp_err), 32'd1);
`else
        check("resp_err_tied", 32'(resp_err), 32'd0);
`endif
        @(negedge clk);
        check("post_rst_idle", 32'(cmd_ready), 32'd1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
